mul_div_unit: RTL

Iterative multiply/divide unit that adds MIPS MULT, MULTU, DIV and DIVU support next to the single-cycle ALU, with architectural HI/LO registers.
Generalised in operand width and handles signed and unsigned modes.
Shift-add multiplier and restoring divider, one bit per cycle.
The controller stalls instruction issue on busy; MFHI/MFLO read hi/lo directly; MTHI/MTLO write them through hi_we/lo_we.

---
 rtl/mul_div_unit_if.sv | 27 ++
 rtl/mul_div_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the instruction controller and the multiply/divide unit.
// Carries operation launch, MTHI/MTLO writes, and the architectural HI/LO state.
interface mul_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO: shift-add multiply, restoring divide, one bit per cycle.
// Optional EARLY_TERM_EN: zero-operand multiplies and divide-by-zero finish at the start edge.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mul_div_if.slave  bus
);
  localparam int unsigned W     = WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             load, step, last;
`ifdef EARLY_TERM_EN
  logic             early;
  logic             zero_c;
`endif
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q, neg_q_q, neg_r_q, dz_q;
  logic [W-1:0]     a_q, m_q, r_q, l_q;
  logic             busy_q, done_q;
  logic [W-1:0]     hi_q, lo_q;

  // Operand magnitudes and sign flags at launch; unsigned ops never see a sign
  logic         sgn_a, sgn_b;
  logic [W-1:0] abs_a, abs_b;
  assign sgn_a = ~bus.op[0] & bus.a[W-1];
  assign sgn_b = ~bus.op[0] & bus.b[W-1];
  assign abs_a = sgn_a ? -bus.a : bus.a;
  assign abs_b = sgn_b ? -bus.b : bus.b;

`ifdef EARLY_TERM_EN
  assign zero_c = bus.op[1] ? (bus.b == '0) : ((bus.a == '0) || (bus.b == '0));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
`ifdef EARLY_TERM_EN
    early   = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
`ifdef EARLY_TERM_EN
          if (zero_c) begin
            early   = 1'b1;
            state_d = DONE;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One iteration: r holds the running upper half / partial remainder, l the shifting lower half / quotient
  logic [W:0]     mul_sum;
  logic [W:0]     div_sh;
  logic [W+1:0]   div_diff;
  logic [W-1:0]   r_n, l_n;
  assign mul_sum  = {1'b0, r_q} + ({1'b0, m_q} & {(W+1){l_q[0]}});
  assign div_sh   = {r_q, l_q[W-1]};
  assign div_diff = {1'b0, div_sh} - {2'b00, m_q};
  assign r_n = is_div_q ? (div_diff[W+1] ? div_sh[W-1:0] : div_diff[W-1:0]) : mul_sum[W:1];
  assign l_n = is_div_q ? {l_q[W-2:0], ~div_diff[W+1]} : {mul_sum[0], l_q[W-1:1]};

  // Sign correction applied to the final iteration's values
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   quo, rem, res_hi, res_lo;
  assign prod     = {r_n, l_n};
  assign prod_fix = neg_q_q ? -prod : prod;
  assign quo      = neg_q_q ? -l_n : l_n;
  assign rem      = neg_r_q ? -r_n : r_n;
  assign res_hi   = is_div_q ? (dz_q ? a_q : rem) : prod_fix[2*W-1:W];
  assign res_lo   = is_div_q ? (dz_q ? '1  : quo) : prod_fix[W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      l_q      <= '0;
    end else if (load) begin
      cnt_q    <= CNT_W'(W);
      is_div_q <= bus.op[1];
      neg_q_q  <= sgn_a ^ sgn_b;
      neg_r_q  <= sgn_a;
      dz_q     <= (bus.b == '0);
      a_q      <= bus.a;
      r_q      <= '0;
      m_q      <= bus.op[1] ? abs_b : abs_a;
      l_q      <= bus.op[1] ? abs_a : abs_b;
    end else if (step) begin
      cnt_q    <= cnt_q - CNT_W'(1);
      r_q      <= r_n;
      l_q      <= l_n;
    end
  end

  // Architectural outputs: results, early results, or MTHI/MTLO when idle and not launching
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= (state_d == DONE);
      if (last) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
`ifdef EARLY_TERM_EN
      else if (early) begin
        hi_q <= bus.op[1] ? bus.a : '0;
        lo_q <= bus.op[1] ? '1 : '0;
      end
`endif
      else if ((state_q != RUN) && !bus.start) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
